// File: rtl/hazard_detector.sv
// Pipeline hazard detector: load-use stalls, redirect flush sequencing and return-stack pop wait.
// Optional macro HAZARD_NO_FWD_EN: no forwarding network, so any in-flight EX/MEM write to a source stalls.
module hazard_detector #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned REG_AW       = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rd_addr1,
  input  logic [REG_AW-1:0] id_rd_addr2,
  input  logic              id_rd_en1,
  input  logic              id_rd_en2,
  input  logic [REG_AW-1:0] ex_dest,
  input  logic              ex_mem_read,
  input  logic              ex_reg_write,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic              mem_reg_write,
  input  logic              ex_redirect,
  input  logic              ex_ret,
  input  logic              ret_addr_valid,
  output logic              data_hazard,
  output logic              PC_hazard,
  output logic              pop_haz,
  output logic              stall_pc,
  output logic              stall_ifid,
  output logic              flush_ifid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    POP   = 2'd2
  } state_t;

  // The redirect cycle itself is spent in IDLE, so FLUSH covers the remaining FLUSH_CYCLES-1 cycles.
  localparam bit         MULTI_FLUSH = (FLUSH_CYCLES > 1);
  localparam logic [3:0] FLUSH_LOAD  = MULTI_FLUSH ? 4'(FLUSH_CYCLES - 2) : 4'd0;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic ex_match;
  logic lu;

  assign ex_match = (ex_dest != '0) &&
                    (((ex_dest == id_rd_addr1) && id_rd_en1) ||
                     ((ex_dest == id_rd_addr2) && id_rd_en2));

`ifdef HAZARD_NO_FWD_EN
  logic mem_match;

  assign mem_match = (mem_dest != '0) &&
                     (((mem_dest == id_rd_addr1) && id_rd_en1) ||
                      ((mem_dest == id_rd_addr2) && id_rd_en2));

  assign lu = (ex_reg_write && ex_match) || (mem_reg_write && mem_match);
`else
  // With forwarding only a load still in EX cannot be bypassed; the MEM stage is unused.
  logic unused_mem;

  assign unused_mem = &{1'b0, mem_dest, mem_reg_write};
  assign lu         = ex_mem_read && ex_reg_write && ex_match;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    data_hazard = 1'b0;
    PC_hazard   = 1'b0;
    pop_haz     = 1'b0;

    unique case (state_q)
      IDLE: begin
        PC_hazard   = ex_redirect;
        pop_haz     = ex_ret && !ex_redirect;
        // A redirect squashes the dependent instruction, so it never needs a bubble.
        data_hazard = lu && !ex_redirect && !(ex_ret && !ex_redirect);
        if (ex_redirect) begin
          if (MULTI_FLUSH) begin
            state_d = FLUSH;
            cnt_d   = FLUSH_LOAD;
          end
        end else if (ex_ret && !ret_addr_valid) begin
          state_d = POP;
        end
      end

      FLUSH: begin
        PC_hazard = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      POP: begin
        pop_haz = 1'b1;
        if (ret_addr_valid) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  assign stall_pc   = data_hazard || pop_haz;
  assign stall_ifid = data_hazard || pop_haz;
  assign flush_ifid = PC_hazard;

endmodule

// File: tb/tb_hazard_detector.sv
// Directed-vector bench for hazard_detector (FLUSH_CYCLES=2) with hand-computed expectations.
module tb_hazard_detector;

`ifdef HAZARD_NO_FWD_EN
  localparam bit NO_FWD = 1'b1;
`else
  localparam bit NO_FWD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] id_rd_addr1, id_rd_addr2, ex_dest, mem_dest;
  logic       id_rd_en1, id_rd_en2, ex_mem_read, ex_reg_write, mem_reg_write;
  logic       ex_redirect, ex_ret, ret_addr_valid;
  logic       data_hazard, PC_hazard, pop_haz, stall_pc, stall_ifid, flush_ifid;

  int n_cmp = 0;
  int n_bad = 0;

  hazard_detector #(.FLUSH_CYCLES(2), .REG_AW(5)) dut (
    .clk(clk), .rst(rst),
    .id_rd_addr1(id_rd_addr1), .id_rd_addr2(id_rd_addr2),
    .id_rd_en1(id_rd_en1), .id_rd_en2(id_rd_en2),
    .ex_dest(ex_dest), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
    .mem_dest(mem_dest), .mem_reg_write(mem_reg_write),
    .ex_redirect(ex_redirect), .ex_ret(ex_ret), .ret_addr_valid(ret_addr_valid),
    .data_hazard(data_hazard), .PC_hazard(PC_hazard), .pop_haz(pop_haz),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .flush_ifid(flush_ifid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // Checks all six outputs against one expected vector {dh, pc, pop}.
  task automatic check_all(input string tag, input logic dh, input logic pc, input logic pop);
    check({tag, ".data_hazard"}, data_hazard, dh);
    check({tag, ".PC_hazard"},   PC_hazard,   pc);
    check({tag, ".pop_haz"},     pop_haz,     pop);
    check({tag, ".stall_pc"},    stall_pc,    dh | pop);
    check({tag, ".stall_ifid"},  stall_ifid,  dh | pop);
    check({tag, ".flush_ifid"},  flush_ifid,  pc);
    $display("[%0t] %s: dh=%b pc=%b pop=%b", $time, tag, data_hazard, PC_hazard, pop_haz);
  endtask

  task automatic clear_inputs();
    id_rd_addr1 = '0; id_rd_addr2 = '0; id_rd_en1 = 0; id_rd_en2 = 0;
    ex_dest = '0; ex_mem_read = 0; ex_reg_write = 0;
    mem_dest = '0; mem_reg_write = 0;
    ex_redirect = 0; ex_ret = 0; ret_addr_valid = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lu(input logic [4:0] d, input logic [4:0] a1);
    ex_mem_read = 1; ex_reg_write = 1; ex_dest = d; id_rd_addr1 = a1; id_rd_en1 = 1;
  endtask

  initial begin
    clear_inputs();
    #2;
    check_all("reset", 0, 0, 0);
    tick();
    #2 rst = 1'b1;
    tick();

    // Load-use on source 1
    set_lu(5'd3, 5'd3);
    #2 check_all("lu_src1", 1, 0, 0);
    tick();
    clear_inputs();
    #2 check_all("lu_clear", 0, 0, 0);

    // Zero register never hazards
    set_lu(5'd0, 5'd0);
    #2 check_all("lu_r0", 0, 0, 0);
    tick(); clear_inputs();

    // Disabled source 2 does not match, enabled one does
    ex_mem_read = 1; ex_reg_write = 1; ex_dest = 5'd4; id_rd_addr2 = 5'd4; id_rd_en2 = 0;
    #2 check_all("lu_en2_off", 0, 0, 0);
    id_rd_en2 = 1;
    #1 check_all("lu_en2_on", 1, 0, 0);
    // Non-load write: hazard only without forwarding
    ex_mem_read = 0;
    #1 check_all("alu_raw", NO_FWD, 0, 0);
    tick(); clear_inputs();

    // MEM-stage write
    mem_reg_write = 1; mem_dest = 5'd7; id_rd_addr1 = 5'd7; id_rd_en1 = 1;
    #2 check_all("mem_raw", NO_FWD, 0, 0);
    mem_dest = 5'd0; id_rd_addr1 = 5'd0;
    #1 check_all("mem_r0", 0, 0, 0);
    tick(); clear_inputs();

    // Redirect with concurrent load-use: two flush cycles, second redirect ignored
    set_lu(5'd3, 5'd3); ex_redirect = 1;
    #2 check_all("redir_c1", 0, 1, 0);
    tick();
    ex_redirect = 1; ex_ret = 1;
    #2 check_all("redir_c2", 0, 1, 0);
    tick();
    clear_inputs();
    #2 check_all("redir_done", 0, 0, 0);
    tick();
    #2 check_all("redir_quiet", 0, 0, 0);

    // Ret with address ready three cycles later: four pop cycles
    ex_ret = 1;
    #2 check_all("ret_c1", 0, 0, 1);
    tick(); ex_ret = 0;
    set_lu(5'd9, 5'd9);
    #2 check_all("ret_c2", 0, 0, 1);
    tick(); clear_inputs();
    #2 check_all("ret_c3", 0, 0, 1);
    tick(); ret_addr_valid = 1;
    #2 check_all("ret_c4", 0, 0, 1);
    tick(); ret_addr_valid = 0;
    #2 check_all("ret_done", 0, 0, 0);

    // Ret with address ready in the same cycle
    ex_ret = 1; ret_addr_valid = 1;
    #2 check_all("ret_fast", 0, 0, 1);
    tick(); clear_inputs();
    #2 check_all("ret_fast_done", 0, 0, 0);

    // Redirect and ret together: redirect wins
    ex_redirect = 1; ex_ret = 1;
    #2 check_all("redir_ret_c1", 0, 1, 0);
    tick(); clear_inputs();
    #2 check_all("redir_ret_c2", 0, 1, 0);
    tick();
    #2 check_all("redir_ret_done", 0, 0, 0);

    // Async reset mid-FLUSH
    ex_redirect = 1;
    tick(); clear_inputs();
    #1 check_all("pre_rst_flush", 0, 1, 0);
    #1 rst = 1'b0;
    #1 check_all("rst_mid_flush", 0, 0, 0);
    tick();
    #2 rst = 1'b1;
    tick();
    #1 check_all("post_rst_flush", 0, 0, 0);

    // Async reset mid-POP
    ex_ret = 1;
    tick(); clear_inputs();
    #1 check_all("pre_rst_pop", 0, 0, 1);
    #1 rst = 1'b0;
    #1 check_all("rst_mid_pop", 0, 0, 0);
    tick();
    #2 rst = 1'b1;
    tick();
    #1 check_all("post_rst_pop", 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
